// File: rtl/ysyx_23060187_ifu_fetch.sv
// Instruction fetch stage: issues one AXI-lite-style read per PC and holds the
// returned instruction for decode; errors park the stage in ERR until reset.
module ysyx_23060187_ifu_fetch #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             fetch_en,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic             pc_advance,
  output logic             fetch_err,
  output logic [31:0]      err_pc,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          timed_out;

  // The counter holds the number of completed WAIT cycles, so the cycle that
  // would make it reach TIMEOUT is the one that raises the error.
  assign timed_out  = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));
  assign pc_advance = (state == HOLD) && inst_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      err_pc     <= '0;
      err_code   <= '0;
      fetch_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            if (pc[1:0] == 2'b00) begin
              araddr  <= pc;
              arvalid <= 1'b1;
              state   <= REQ;
            end else begin
              err_pc    <= pc;
              err_code  <= 2'd1;
              fetch_err <= 1'b1;
              state     <= ERR;
            end
          end
        end
        REQ: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (rvalid) begin
            rready   <= 1'b0;
            wait_cnt <= '0;
            if (rresp == 2'b00) begin
              inst       <= rdata;
              inst_pc    <= araddr;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              err_pc    <= araddr;
              err_code  <= 2'd2;
              fetch_err <= 1'b1;
              state     <= ERR;
            end
          end else if (timed_out) begin
            rready    <= 1'b0;
            wait_cnt  <= '0;
            err_pc    <= araddr;
            err_code  <= 2'd3;
            fetch_err <= 1'b1;
            state     <= ERR;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + CNT_W'(1);
            state      <= IDLE;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_ifu_fetch.sv
// Self-checking bench for ysyx_23060187_ifu_fetch: directed and randomized
// fetches checked cycle by cycle against a transaction-level expectation.
module tb_ysyx_23060187_ifu_fetch;

  localparam int TO0 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] pc = '0;
  logic        fetch_en = 1'b0;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        pc_advance;
  logic        fetch_err;
  logic [31:0] err_pc;
  logic [1:0]  err_code;
  logic [31:0] fetch_cnt;

  logic [31:0] d1_pc = '0;
  logic        d1_fetch_en = 1'b0;
  logic [31:0] d1_araddr;
  logic        d1_arvalid;
  logic        d1_arready = 1'b0;
  logic [31:0] d1_rdata = '0;
  logic [1:0]  d1_rresp = '0;
  logic        d1_rvalid = 1'b0;
  logic        d1_rready;
  logic [31:0] d1_inst;
  logic [31:0] d1_inst_pc;
  logic        d1_inst_valid;
  logic        d1_inst_ready = 1'b0;
  logic        d1_pc_advance;
  logic        d1_fetch_err;
  logic [31:0] d1_err_pc;
  logic [1:0]  d1_err_code;
  logic [31:0] d1_fetch_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expCnt = '0;

  always #5 clk = ~clk;

  ysyx_23060187_ifu_fetch #(.CNT_W(32), .TIMEOUT(TO0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .pc_advance(pc_advance),
    .fetch_err(fetch_err), .err_pc(err_pc), .err_code(err_code),
    .fetch_cnt(fetch_cnt)
  );

  ysyx_23060187_ifu_fetch #(.CNT_W(32), .TIMEOUT(0)) dut1 (
    .clk(clk), .rst(rst), .pc(d1_pc), .fetch_en(d1_fetch_en),
    .araddr(d1_araddr), .arvalid(d1_arvalid), .arready(d1_arready),
    .rdata(d1_rdata), .rresp(d1_rresp), .rvalid(d1_rvalid), .rready(d1_rready),
    .inst(d1_inst), .inst_pc(d1_inst_pc), .inst_valid(d1_inst_valid),
    .inst_ready(d1_inst_ready), .pc_advance(d1_pc_advance),
    .fetch_err(d1_fetch_err), .err_pc(d1_err_pc), .err_code(d1_err_code),
    .fetch_cnt(d1_fetch_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_araddr", araddr, 0);
    checkOutput("rst_arvalid", arvalid, 0);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_inst", inst, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_pc_advance", pc_advance, 0);
    checkOutput("rst_fetch_err", fetch_err, 0);
    checkOutput("rst_err_pc", err_pc, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_fetch_cnt", fetch_cnt, 0);
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    checkResetOutputs();
    step();
    step();
    rst = 1'b1;
    expCnt = '0;
  endtask

  // Once errored, every input is ignored and the error record stays put.
  task automatic holdInErr(input logic [1:0] code, input logic [31:0] addr, input int n);
    for (int i = 0; i < n; i++) begin
      fetch_en = 1'b1;
      pc = $urandom & 32'hFFFF_FFFC;
      arready = 1'($urandom_range(0, 1));
      rvalid = 1'($urandom_range(0, 1));
      rresp = 2'($urandom);
      inst_ready = 1'($urandom_range(0, 1));
      settle();
      checkOutput("err_sticky", fetch_err, 1);
      checkOutput("err_code_frozen", err_code, code);
      checkOutput("err_pc_frozen", err_pc, addr);
      checkOutput("err_arvalid", arvalid, 0);
      checkOutput("err_inst_valid", inst_valid, 0);
      checkOutput("err_pc_advance", pc_advance, 0);
      step();
    end
    fetch_en = 1'b0;
  endtask

  // One complete fetch starting from IDLE; delays are counted in cycles the
  // memory or decode stalls before handshaking.
  task automatic applyStimulus(input logic [31:0] addr, input int arWait, input int rWait,
                               input logic [1:0] resp, input logic [31:0] data, input int holdWait);
    int waitCycles;
    logic [1:0] expCode;
    pc = addr;
    fetch_en = 1'b1;
    arready = 1'b0;
    rvalid = 1'b0;
    inst_ready = 1'($urandom_range(0, 1));
    settle();
    checkOutput("idle_arvalid", arvalid, 0);
    checkOutput("idle_pc_advance", pc_advance, 0);
    step();
    fetch_en = 1'($urandom_range(0, 1));
    if (addr[1:0] != 2'b00) begin
      settle();
      checkOutput("mis_fetch_err", fetch_err, 1);
      checkOutput("mis_err_code", err_code, 1);
      checkOutput("mis_err_pc", err_pc, addr);
      checkOutput("mis_arvalid", arvalid, 0);
      return;
    end
    for (int i = 0; i <= arWait; i++) begin
      pc = $urandom;
      arready = (i == arWait);
      rvalid = 1'($urandom_range(0, 1));
      rdata = $urandom;
      rresp = 2'($urandom);
      inst_ready = 1'($urandom_range(0, 1));
      settle();
      checkOutput("req_arvalid", arvalid, 1);
      checkOutput("req_araddr", araddr, addr);
      checkOutput("req_rready", rready, 0);
      checkOutput("req_inst_valid", inst_valid, 0);
      step();
    end
    arready = 1'b0;
    inst_ready = 1'b0;
    waitCycles = (rWait < TO0) ? rWait + 1 : TO0;
    for (int j = 0; j < waitCycles; j++) begin
      rvalid = (j == rWait);
      rdata = data;
      rresp = (j == rWait) ? resp : 2'($urandom);
      settle();
      checkOutput("wait_rready", rready, 1);
      checkOutput("wait_arvalid", arvalid, 0);
      checkOutput("wait_fetch_err", fetch_err, 0);
      step();
    end
    rvalid = 1'($urandom_range(0, 1));
    rdata = $urandom;
    rresp = 2'($urandom);
    if (rWait >= TO0 || resp != 2'b00) begin
      expCode = (rWait >= TO0) ? 2'd3 : 2'd2;
      settle();
      checkOutput("rsp_fetch_err", fetch_err, 1);
      checkOutput("rsp_err_code", err_code, expCode);
      checkOutput("rsp_err_pc", err_pc, addr);
      checkOutput("rsp_inst_valid", inst_valid, 0);
      checkOutput("rsp_rready", rready, 0);
      return;
    end
    for (int k = 0; k <= holdWait; k++) begin
      inst_ready = (k == holdWait);
      fetch_en = 1'($urandom_range(0, 1));
      pc = $urandom;
      settle();
      checkOutput("hold_inst_valid", inst_valid, 1);
      checkOutput("hold_inst", inst, data);
      checkOutput("hold_inst_pc", inst_pc, addr);
      checkOutput("hold_pc_advance", pc_advance, (k == holdWait));
      checkOutput("hold_rready", rready, 0);
      checkOutput("hold_fetch_cnt", fetch_cnt, expCnt);
      step();
    end
    expCnt = expCnt + 1;
    inst_ready = 1'b0;
    fetch_en = 1'b0;
    rvalid = 1'b0;
    settle();
    checkOutput("done_inst_valid", inst_valid, 0);
    checkOutput("done_pc_advance", pc_advance, 0);
    checkOutput("done_fetch_cnt", fetch_cnt, expCnt);
    checkOutput("done_fetch_err", fetch_err, 0);
    step();
  endtask

  initial begin
    #2;
    checkResetOutputs();
    step();
    step();
    rst = 1'b1;

    applyStimulus(32'h8000_0000, 0, 0, 2'd0, 32'h0000_0413, 0);
    applyStimulus(32'h8000_0008, 3, 1, 2'd0, $urandom, 5);

    for (int n = 0; n < 20; n++) begin
      applyStimulus($urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), $urandom_range(0, 3),
                    2'd0, $urandom, $urandom_range(0, 3));
    end

    applyStimulus(32'h8000_0002, 0, 0, 2'd0, 32'h0, 0);
    holdInErr(2'd1, 32'h8000_0002, 5);
    doReset();

    applyStimulus(32'h8000_0010, 1, 2, 2'd2, $urandom, 0);
    holdInErr(2'd2, 32'h8000_0010, 5);
    doReset();

    applyStimulus(32'h8000_0030, 0, 9, 2'd0, $urandom, 0);
    holdInErr(2'd3, 32'h8000_0030, 3);
    doReset();

    applyStimulus(32'h8000_0040, 0, 0, 2'd0, 32'h1234_5678, 0);
    pc = 32'h8000_0050;
    fetch_en = 1'b1;
    arready = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    arready = 1'b0;
    settle();
    checkOutput("mid_in_wait", rready, 1);
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs();
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    rresp = 2'd0;
    step();
    rst = 1'b1;
    expCnt = '0;
    step();
    rvalid = 1'b0;
    settle();
    checkOutput("mid_no_completion", inst_valid, 0);
    step();
    applyStimulus(32'h8000_0004, 0, 0, 2'd0, 32'h0000_0013, 1);

    d1_pc = 32'h8000_0020;
    d1_fetch_en = 1'b1;
    d1_arready = 1'b1;
    step();
    d1_fetch_en = 1'b0;
    step();
    d1_arready = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      settle();
      checkOutput("noto_rready", d1_rready, 1);
      checkOutput("noto_fetch_err", d1_fetch_err, 0);
      step();
    end
    d1_rvalid = 1'b1;
    d1_rdata = 32'h0000_0093;
    step();
    d1_rvalid = 1'b0;
    settle();
    checkOutput("noto_inst_valid", d1_inst_valid, 1);
    checkOutput("noto_inst", d1_inst, 32'h0000_0093);
    checkOutput("noto_inst_pc", d1_inst_pc, 32'h8000_0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060187_ifu_fetch.md
Name: ysyx_23060187_ifu_fetch

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Takes the current PC, issues a single-beat read on an AXI-lite-style instruction memory port, and holds the returned instruction for decode under a valid/ready handshake.
- Pulses pc_advance when decode accepts an instruction, so the PC register updates only after a fetch has completed.
- Detects misaligned PCs, bus errors and response timeouts.

Parameters:
- CNT_W, 32: width of the retired-fetch counter.
- TIMEOUT, 255: maximum number of WAIT cycles before a timeout error is raised. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- pc  in  32  current PC from the PC register.
- fetch_en  in  1  permission to start a new fetch.
- araddr  out  32  read address.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready.
- rdata  in  32  read data.
- rresp  in  2  read response; 0 = OKAY, any other value = error.
- rvalid  in  1  read-data valid.
- rready  out  1  read-data ready.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of inst.
- inst_valid  out  1  inst is valid for decode.
- inst_ready  in  1  decode accepts inst.
- pc_advance  out  1  one-cycle pulse on the decode handshake; the PC register updates on it.
- fetch_err  out  1  sticky error flag.
- err_pc  out  32  address that caused the error.
- err_code  out  2  error cause: 1 = misaligned, 2 = bus error, 3 = timeout.
- fetch_cnt  out  CNT_W  count of instructions accepted by decode.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, including araddr, inst, inst_pc, err_pc, err_code and fetch_cnt. The wait counter clears. Reset asserted mid-transaction abandons the transaction; no completion is reported afterwards.
- States: IDLE, REQ, WAIT, HOLD, ERR. All outputs are registered except pc_advance.
- IDLE:
  - fetch_en=1 and pc[1:0]==0: latch araddr<=pc, go to REQ.
  - fetch_en=1 and pc[1:0]!=0: err_pc<=pc, err_code<=1, go to ERR.
  - fetch_en=0: stay in IDLE.
- REQ: arvalid=1, araddr held stable. On arready=1, go to WAIT. arvalid deasserts the same edge.
- WAIT: rready=1. Wait counter increments every cycle.
  - rvalid=1, rresp==0: inst<=rdata, inst_pc<=araddr, go to HOLD.
  - rvalid=1, rresp!=0: err_pc<=araddr, err_code<=2, go to ERR.
  - TIMEOUT!=0 and counter reaches TIMEOUT without rvalid: err_code<=3, err_pc<=araddr, go to ERR.
  - rvalid arriving outside WAIT is ignored, because rready=0.
  - The wait counter clears on leaving WAIT.
- HOLD: inst_valid=1; inst and inst_pc held stable.
  - inst_ready=1: pc_advance=1 in that cycle (combinational: state==HOLD && inst_ready), fetch_cnt increments (wraps at 2^CNT_W), go to IDLE.
  - inst_ready=0: hold indefinitely.
- ERR: fetch_err=1; err_pc and err_code frozen. arvalid, rready, inst_valid and pc_advance are 0. Ignores every input; exits only on reset.
- Minimum latency: fetch_en at edge N, arvalid high in cycle N+1. arready=1 there gives WAIT at N+2. rvalid=1 at N+2 gives inst_valid at N+3. inst_ready=1 gives pc_advance in N+3 and IDLE at N+4. This is 4 cycles per instruction at zero memory wait.
- Only one outstanding transaction at a time. fetch_en is not sampled outside IDLE.
- pc is sampled only on the IDLE->REQ transition. Later changes to pc do not affect an in-flight fetch.

Test Plan:
- Reset, then pc=0x80000000, fetch_en=1, arready=1, and rvalid=1 with rdata=0x00000413, rresp=0 in WAIT, inst_ready=1:
  - araddr=0x80000000 with arvalid in cycle 1.
  - inst=0x00000413, inst_pc=0x80000000, inst_valid in cycle 3.
  - pc_advance pulses once; fetch_cnt=1.
- Back-pressure:
  - arready=0 for 3 cycles: arvalid and araddr stay stable throughout.
  - inst_ready=0 for 5 cycles: inst_valid stays 1, inst unchanged, pc_advance stays 0.
  - Then inst_ready=1: exactly one pc_advance.
- pc=0x80000002, fetch_en=1: fetch_err=1, err_code=1, err_pc=0x80000002. arvalid never asserts.
- Bus error at pc=0x80000010 (rresp=2): fetch_err=1, err_code=2, err_pc=0x80000010, no inst_valid. Further fetch_en is ignored until reset.
- Timeout: TIMEOUT=4, rvalid held at 0 → ERR entered after 4 WAIT cycles with err_code=3. Rerun with TIMEOUT=0 → stays in WAIT for 1000 cycles.
- Reset mid-fetch:
  - rst=0 asynchronously during WAIT: all outputs 0 immediately.
  - After release, a fresh fetch from pc=0x80000004 completes normally; fetch_cnt restarts from 0.
